inner_loop_pipe: RTL

- Parametrised successor of the fixed 3072x78 inner-loop partial-product engine. Multiplies wide operand `a` by one radix digit `bi`; result is a redundant (carry-save) pair `r0`, `r1`.
- Operand is split into RADIX-wide digits and issued BLOCKS digits per cycle over NPASS passes through a MUL_LAT-stage multiplier pipeline.
- Adds a valid/ready handshake on both sides, output hold under back-pressure, and back-to-back acceptance.
- Sits inside the Montgomery outer loop, feeding the carry-save accumulator.

---
 rtl/inner_loop_pipe.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/inner_loop_pipe.sv
// Radix-digit inner-loop engine: a * bi as a carry-save pair (r0 = low halves,
// r1 = high halves shifted up one digit), issued BLOCKS digits per pass.

module inner_loop_dmul #(
    parameter int RADIX = 78,
    parameter int LAT   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RADIX-1:0]   x,
    input  logic [RADIX-1:0]   y,
    output logic [2*RADIX-1:0] p
);
    logic [LAT-1:0][2*RADIX-1:0] stg;

    always_ff @(posedge clk) begin
        if (rst) stg <= '0;
        else     stg <= (LAT*2*RADIX)'({stg, (2*RADIX)'(x) * (2*RADIX)'(y)});
    end

    assign p = stg[LAT-1];
endmodule

module inner_loop_pipe #(
    parameter int SIZE    = 3072,
    parameter int RADIX   = 78,
    parameter int BLOCKS  = 20,
    parameter int MUL_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SIZE+1:0]         a,
    input  logic [RADIX-1:0]        bi,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SIZE+RADIX+1:0]   r0,
    output logic [SIZE+RADIX+1:0]   r1,
    output logic                    busy
);
    localparam int NDIG  = (SIZE + 2 + RADIX - 1) / RADIX;
    localparam int NPASS = (NDIG + BLOCKS - 1) / BLOCKS;
    localparam int W     = SIZE + RADIX + 2;
    localparam int AW    = NPASS * BLOCKS * RADIX;
    localparam int PW    = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam int DW    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [PW-1:0] LAST_PASS  = PW'(NPASS - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(MUL_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                                   state;
    logic [NPASS-1:0][BLOCKS-1:0][RADIX-1:0]  a_q;
    logic [RADIX-1:0]                         bi_q;
    logic [PW-1:0]                            pass;
    logic [DW-1:0]                            dcnt;
    logic [MUL_LAT-1:0]                       vld_pipe;
    logic [MUL_LAT-1:0][PW-1:0]               pass_pipe;
    logic [BLOCKS-1:0][2*RADIX-1:0]           prod;
    logic [NDIG-1:0][RADIX-1:0]               r0_full;
    logic [NDIG-1:0][RADIX-1:0]               r1_full;
    logic                                     accept;
    logic                                     issue;

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign issue    = (state == ISSUE);

    // Pad digits beyond NDIG are zero in a_q, so their lanes multiply 0.
    for (genvar k = 0; k < BLOCKS; k++) begin : g_lane
        inner_loop_dmul #(.RADIX(RADIX), .LAT(MUL_LAT)) u_mul (
            .clk (clk),
            .rst (rst),
            .x   (a_q[pass][k]),
            .y   (bi_q),
            .p   (prod[k])
        );
    end

    // Each live digit owns its slot; only the pass that issued it may write it.
    for (genvar d = 0; d < NDIG; d++) begin : g_dig
        localparam int P = d / BLOCKS;
        localparam int K = d % BLOCKS;
        logic [RADIX-1:0] lo_q, hi_q;

        always_ff @(posedge clk) begin
            if (rst || accept) begin
                lo_q <= '0;
                hi_q <= '0;
            end else if (vld_pipe[MUL_LAT-1] && pass_pipe[MUL_LAT-1] == PW'(P)) begin
                {hi_q, lo_q} <= prod[K];
            end
        end

        assign r0_full[d] = lo_q;
        assign r1_full[d] = hi_q;
    end

    assign r0 = W'(r0_full);
    assign r1 = W'({r1_full, {RADIX{1'b0}}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            bi_q      <= '0;
            pass      <= '0;
            dcnt      <= '0;
            vld_pipe  <= '0;
            pass_pipe <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            vld_pipe  <= MUL_LAT'({vld_pipe, issue});
            pass_pipe <= (MUL_LAT*PW)'({pass_pipe, pass});
            if (accept) begin
                a_q       <= AW'(a);
                bi_q      <= bi;
                pass      <= '0;
                state     <= ISSUE;
                busy      <= 1'b1;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    ISSUE: begin
                        if (pass == LAST_PASS) begin
                            state <= DRAIN;
                            dcnt  <= '0;
                        end else begin
                            pass <= pass + PW'(1);
                        end
                    end
                    DRAIN: begin
                        if (dcnt == LAST_DRAIN) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            dcnt <= dcnt + DW'(1);
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
